// File: rtl/drop_ctrl_if.sv
// Move handshake between a requester and the drop_ctrl board engine.
interface drop_ctrl_if;
  logic       move_valid;
  logic [2:0] move_col;
  logic       move_ready;
  logic       move_done;
  logic       move_err;

  modport master (
    output move_valid,
    output move_col,
    input  move_ready,
    input  move_done,
    input  move_err
  );

  modport slave (
    input  move_valid,
    input  move_col,
    output move_ready,
    output move_done,
    output move_err
  );
endinterface

// File: rtl/drop_ctrl.sv
// Drop-in board controller: 7 columns x 6 rows, pieces fall to the lowest
// empty cell of the chosen column, one cell examined per cycle.
module drop_ctrl (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  new_game,
  drop_ctrl_if.slave            mv,
  output logic [6:0][5:0][1:0]  panel,
  output logic [1:0]            turn,
  output logic [2:0]            last_col,
  output logic [2:0]            last_row,
  output logic                  full
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SCAN = 3'd1;
  localparam logic [2:0] DONE = 3'd2;
  localparam logic [2:0] ERR  = 3'd3;
  localparam logic [2:0] OVER = 3'd4;

  localparam logic [1:0] P1    = 2'b01;
  localparam logic [1:0] P2    = 2'b10;
  localparam logic [1:0] EMPTY = 2'b00;

  // Board is full when no column has room left in its top row.
  function automatic logic board_full(input logic [6:0][5:0][1:0] b);
    logic f;
    f = 1'b1;
    for (int c = 0; c < 7; c++) begin
      f = f & (b[c][0] != EMPTY);
    end
    return f;
  endfunction

  logic [2:0]                state_q, state_d;
  logic [6:0][5:0][1:0]      panel_q, panel_d;
  logic [1:0]                turn_q, turn_d;
  logic                      full_q, full_d;
  logic [2:0]                last_col_q, last_col_d;
  logic [2:0]                last_row_q, last_row_d;
  logic [2:0]                col_q, col_d;
  logic [2:0]                row_q, row_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic                      ready_s;
  logic                      accept_s;
  logic                      col_bad_s;

  assign ready_s  = (state_q == IDLE) && !full_q && !new_game && !rst;
  assign accept_s = mv.move_valid && ready_s;
  // Out-of-range column or a column whose top cell is taken is rejected;
  // the range check guards the panel read.
  assign col_bad_s = (mv.move_col > 3'd6) ? 1'b1 : (panel_q[mv.move_col][0] != EMPTY);

  // Next-state logic: move acceptance, per-cycle column scan and new_game clear.
  always_comb begin
    state_d    = state_q;
    panel_d    = panel_q;
    turn_d     = turn_q;
    full_d     = full_q;
    last_col_d = last_col_q;
    last_row_d = last_row_q;
    col_d      = col_q;
    row_d      = row_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (new_game) begin
      state_d    = IDLE;
      panel_d    = '0;
      turn_d     = P1;
      full_d     = 1'b0;
      last_col_d = 3'd0;
      last_row_d = 3'd0;
      col_d      = 3'd0;
      row_d      = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s && col_bad_s) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else if (accept_s) begin
            col_d   = mv.move_col;
            row_d   = 3'd5;
            state_d = SCAN;
          end else begin
            state_d = IDLE;
          end
        end
        SCAN: begin
          if (panel_q[col_q][row_q] == EMPTY) begin
            panel_d[col_q][row_q] = turn_q;
            last_col_d            = col_q;
            last_row_d            = row_q;
            state_d               = DONE;
            done_d                = 1'b1;
          end else if (row_q == 3'd0) begin
            // Unreachable while the top-row check holds; never loop forever.
            state_d = IDLE;
          end else begin
            row_d = row_q - 3'd1;
          end
        end
        DONE: begin
          turn_d  = (turn_q == P1) ? P2 : P1;
          full_d  = board_full(panel_q);
          state_d = board_full(panel_q) ? OVER : IDLE;
        end
        ERR: begin
          state_d = IDLE;
        end
        OVER: begin
          state_d = OVER;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      panel_q    <= '0;
      turn_q     <= P1;
      full_q     <= 1'b0;
      last_col_q <= 3'd0;
      last_row_q <= 3'd0;
      col_q      <= 3'd0;
      row_q      <= 3'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      panel_q    <= panel_d;
      turn_q     <= turn_d;
      full_q     <= full_d;
      last_col_q <= last_col_d;
      last_row_q <= last_row_d;
      col_q      <= col_d;
      row_q      <= row_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign mv.move_ready = ready_s;
  assign mv.move_done  = done_q;
  assign mv.move_err   = err_q;
  assign panel         = panel_q;
  assign turn          = turn_q;
  assign full          = full_q;
  assign last_col      = last_col_q;
  assign last_row      = last_row_q;

endmodule

// File: tb/tb_drop_ctrl.sv
// Directed, table-driven bench for drop_ctrl.
module tb_drop_ctrl;

  logic                  clk;
  logic                  rst;
  logic                  new_game;
  logic [6:0][5:0][1:0]  panel;
  logic [1:0]            turn;
  logic [2:0]            last_col;
  logic [2:0]            last_row;
  logic                  full;

  drop_ctrl_if bus ();

  drop_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .new_game (new_game),
    .mv       (bus),
    .panel    (panel),
    .turn     (turn),
    .last_col (last_col),
    .last_row (last_row),
    .full     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0][5:0][1:0] model;
  logic [1:0]           exp_turn;

  typedef struct {
    bit        op_ng;     // 1: issue new_game instead of a move
    logic [2:0] col;
    bit        exp_err;
    logic [2:0] exp_row;
    logic [1:0] exp_player;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    model    = '0;
    exp_turn = 2'b01;
    @(negedge clk);
    chk("ng_panel", panel, '0);
    chk("ng_turn", turn, 2'b01);
    chk("ng_full", full, 1'b0);
    chk("ng_last", {last_col, last_row}, 6'd0);
    chk("ng_done_err", {bus.move_done, bus.move_err}, 2'b00);
    chk("ng_ready", bus.move_ready, 1'b1);
    tick();
  endtask

  // Issue one move at the current cycle T and check result, latency and board.
  task automatic apply_move(input logic [2:0] col, input bit exp_err,
                            input logic [2:0] exp_row, input logic [1:0] exp_player,
                            input bit exp_full);
    int cyc;
    bit got;
    bus.move_valid = 1'b1;
    bus.move_col   = col;
    @(negedge clk);
    chk("mv_ready_at_T", bus.move_ready, 1'b1);
    tick();
    bus.move_valid = 1'b0;
    cyc = 1;
    got = 1'b0;
    while (cyc < 12 && !got) begin
      @(negedge clk);
      if (bus.move_done || bus.move_err) begin
        got = 1'b1;
      end else begin
        tick();
        cyc++;
      end
    end
    chk("mv_response_seen", got, 1'b1);
    if (exp_err) begin
      chk("err_flags", {bus.move_done, bus.move_err}, 2'b01);
      chk("err_latency", cyc, 1);
    end else begin
      model[col][exp_row] = exp_player;
      exp_turn = (exp_turn == 2'b01) ? 2'b10 : 2'b01;
      chk("done_flags", {bus.move_done, bus.move_err}, 2'b10);
      chk("done_latency", cyc, 2 + (5 - int'(exp_row)));
      chk("last_col", last_col, col);
      chk("last_row", last_row, exp_row);
    end
    chk("panel_after", panel, model);
    tick();
    @(negedge clk);
    chk("pulse_one_cycle", {bus.move_done, bus.move_err}, 2'b00);
    chk("turn_after", turn, exp_turn);
    chk("ready_after", bus.move_ready, !exp_full);
    chk("full_after", full, exp_full);
    tick();
  endtask

  initial begin
    rst            = 1'b1;
    new_game       = 1'b0;
    bus.move_valid = 1'b0;
    bus.move_col   = 3'd0;
    model          = '0;
    exp_turn       = 2'b01;

    vecs[0]  = '{1'b1, 3'd0, 1'b0, 3'd0, 2'b00};
    vecs[1]  = '{1'b0, 3'd3, 1'b0, 3'd5, 2'b01};
    vecs[2]  = '{1'b1, 3'd0, 1'b0, 3'd0, 2'b00};
    vecs[3]  = '{1'b0, 3'd0, 1'b0, 3'd5, 2'b01};
    vecs[4]  = '{1'b0, 3'd0, 1'b0, 3'd4, 2'b10};
    vecs[5]  = '{1'b0, 3'd0, 1'b0, 3'd3, 2'b01};
    vecs[6]  = '{1'b0, 3'd0, 1'b0, 3'd2, 2'b10};
    vecs[7]  = '{1'b0, 3'd0, 1'b0, 3'd1, 2'b01};
    vecs[8]  = '{1'b0, 3'd0, 1'b0, 3'd0, 2'b10};
    vecs[9]  = '{1'b0, 3'd0, 1'b1, 3'd0, 2'b00};
    vecs[10] = '{1'b0, 3'd7, 1'b1, 3'd0, 2'b00};
    vecs[11] = '{1'b0, 3'd6, 1'b0, 3'd5, 2'b01};

    repeat (2) tick();
    @(negedge clk);
    chk("ready_in_rst", bus.move_ready, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_panel", panel, '0);
    chk("rst_turn", turn, 2'b01);
    chk("rst_full", full, 1'b0);
    chk("rst_last", {last_col, last_row}, 6'd0);
    chk("rst_done_err", {bus.move_done, bus.move_err}, 2'b00);
    chk("rst_ready", bus.move_ready, 1'b1);
    tick();

    // Table-driven moves: first drop, column stack, rejected moves.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].op_ng) begin
        do_new_game();
      end else begin
        chk("tbl_player_matches_turn", exp_turn,
            vecs[i].exp_err ? exp_turn : vecs[i].exp_player);
        apply_move(vecs[i].col, vecs[i].exp_err, vecs[i].exp_row,
                   vecs[i].exp_player, 1'b0);
      end
    end

    // Fill the whole board column by column.
    do_new_game();
    for (int n = 0; n < 42; n++) begin
      apply_move(3'(n / 6), 1'b0, 3'(5 - (n % 6)), exp_turn, n == 41);
    end
    // Board is over: further moves must be ignored.
    bus.move_valid = 1'b1;
    bus.move_col   = 3'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("over_ready", bus.move_ready, 1'b0);
      chk("over_no_resp", {bus.move_done, bus.move_err}, 2'b00);
      tick();
    end
    bus.move_valid = 1'b0;
    chk("over_panel", panel, model);
    chk("over_full", full, 1'b1);
    do_new_game();

    // Reset during the second SCAN cycle of a drop into column 2.
    for (int i = 0; i < 4; i++) begin
      apply_move(3'd2, 1'b0, 3'(5 - i), exp_turn, 1'b0);
    end
    bus.move_valid = 1'b1;
    bus.move_col   = 3'd2;
    tick();
    bus.move_valid = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_scan_ready", bus.move_ready, 1'b0);
    tick();
    rst      = 1'b0;
    model    = '0;
    exp_turn = 2'b01;
    @(negedge clk);
    chk("rst_scan_panel", panel, '0);
    chk("rst_scan_turn", turn, 2'b01);
    chk("rst_scan_full", full, 1'b0);
    chk("rst_scan_last", {last_col, last_row}, 6'd0);
    chk("rst_scan_done_err", {bus.move_done, bus.move_err}, 2'b00);
    chk("rst_scan_ready_back", bus.move_ready, 1'b1);
    tick();

    // new_game together with move_valid: move is not accepted.
    apply_move(3'd4, 1'b0, 3'd5, 2'b01, 1'b0);
    new_game       = 1'b1;
    bus.move_valid = 1'b1;
    bus.move_col   = 3'd4;
    @(negedge clk);
    chk("ng_mv_ready", bus.move_ready, 1'b0);
    tick();
    new_game       = 1'b0;
    bus.move_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ng_mv_no_resp", {bus.move_done, bus.move_err}, 2'b00);
      tick();
    end
    chk("ng_mv_panel", panel, '0);
    chk("ng_mv_turn", turn, 2'b01);
    chk("ng_mv_last", {last_col, last_row}, 6'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
